// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle for the data-memory responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [0:31] req_addr;
  logic        req_we;
  logic [0:1]  req_size;
  logic        req_sign;
  logic [0:31] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:31] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_sign, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_sign, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory with big-endian lanes, extension and request checking
module dmem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter string MemFile     = ""
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [AW-1:0] idx_q;
  logic [0:1]  off_q;
  logic [0:1]  size_q;
  logic        we_q;
  logic        sign_q;
  logic [0:31] wdata_q;
  logic        rsp_valid_q;
  logic [0:31] rsp_rdata_q;
  logic        rsp_err_q;

  logic [0:31] mem [0:DEPTH_WORDS-1];

  logic [31:0] word_index;
  logic        req_bad;
  logic        access;
  logic [0:31] cur_word;
  logic [0:7]  byte_lane;
  logic [0:15] half_lane;
  logic [0:31] load_data;
  logic [0:31] store_word;

  // Range check covers every size: a byte beyond the array is as illegal as a word.
  always_comb begin
    word_index = {2'b00, bus.req_addr[0:29]};
    req_bad    = (bus.req_size == 2'b11)
              || (bus.req_size == 2'b01 && bus.req_addr[31])
              || (bus.req_size == 2'b10 && bus.req_addr[30:31] != 2'b00)
              || (word_index >= 32'(DEPTH_WORDS));
  end

  assign access = (state == S_WAIT) && (cnt == 4'd0);

  always_comb begin
    cur_word = mem[idx_q];
    case (off_q)
      2'd0:    byte_lane = cur_word[0:7];
      2'd1:    byte_lane = cur_word[8:15];
      2'd2:    byte_lane = cur_word[16:23];
      default: byte_lane = cur_word[24:31];
    endcase
    half_lane = off_q[0] ? cur_word[16:31] : cur_word[0:15];

    case (size_q)
      2'b00:   load_data = {{24{sign_q & byte_lane[0]}}, byte_lane};
      2'b01:   load_data = {{16{sign_q & half_lane[0]}}, half_lane};
      default: load_data = cur_word;
    endcase

    store_word = cur_word;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'd0:    store_word[0:7]   = wdata_q[24:31];
          2'd1:    store_word[8:15]  = wdata_q[24:31];
          2'd2:    store_word[16:23] = wdata_q[24:31];
          default: store_word[24:31] = wdata_q[24:31];
        endcase
      end
      2'b01: begin
        if (off_q[0]) store_word[16:31] = wdata_q[16:31];
        else          store_word[0:15]  = wdata_q[16:31];
      end
      default: store_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.req_valid) state_next = req_bad ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Reset gates the write so an abandoned store never reaches the array.
  always_ff @(posedge clk) begin
    if (!reset && access && we_q) mem[idx_q] <= store_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            idx_q   <= bus.req_addr[30-AW:29];
            off_q   <= bus.req_addr[30:31];
            size_q  <= bus.req_size;
            we_q    <= bus.req_we;
            sign_q  <= bus.req_sign;
            wdata_q <= bus.req_wdata;
            if (req_bad) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              cnt <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? 32'd0 : load_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed-vector bench for dmem_responder at LATENCY=2, DEPTH_WORDS=1024
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .MemFile("")) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Issues one request from the #1-after-edge phase and returns its response.
  // lat counts edges after the accept edge until rsp_valid is seen (-1/-2 on timeout).
  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic ready_now;
    int n;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_sign = sign; bus.req_addr = addr; bus.req_wdata = wdata;
    n = 0; ready_now = 1'b0;
    while (!ready_now && n < 20) begin
      ready_now = bus.req_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    rdata = '0; err = 1'b0;
    if (!ready_now) begin lat = -2; return; end
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.rsp_valid !== 1'b1) begin lat = -1; return; end
    rdata = bus.rsp_rdata; err = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_sign = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset req_ready: got %b want 1", bus.req_ready); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
    vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset rsp_rdata: got %h want 00000000", bus.rsp_rdata); end
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset rsp_err: got %b want 0", bus.rsp_err); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    vectors++; if (rd !== 32'h0 || er !== 1'b0 || lat != 2) begin miscompares++; $display("FAIL word_store: got rdata=%h err=%b lat=%0d want 00000000 0 2", rd, er, lat); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin miscompares++; $display("FAIL word_load: got rdata=%h err=%b want deadbeef 0", rd, er); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL word_load latency: got %0d want 2", lat); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addrs [6] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h20, 32'h21};
    logic        signs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h0000007F, 32'h00000001, 32'h00000080, 32'h000000FF};
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, rd, er, lat);
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, 2'b00, signs[i], addrs[i], 32'h0, rd, er, lat);
      vectors++; if (rd !== exps[i] || er !== 1'b0 || lat != 2) begin miscompares++; $display("FAIL byte_load[%0d]: got rdata=%h err=%b lat=%0d want %h 0 2", i, rd, er, lat, exps[i]); end
    end
  endtask

  task automatic test_halfword();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, rd, er, lat);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, rd, er, lat);
    vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("FAIL half_store: got rdata=%h err=%b want 00000000 0", rd, er); end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hAAAA1234) begin miscompares++; $display("FAIL half_merge: got %h want aaaa1234", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hFFFFAAAA) begin miscompares++; $display("FAIL half_signed: got %h want ffffaaaa", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h00001234) begin miscompares++; $display("FAIL half_signed_pos: got %h want 00001234", rd); end
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h12345699, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hAA991234) begin miscompares++; $display("FAIL byte_merge: got %h want aa991234", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic        wes   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sizes [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [31:0] addrs [5] = '{32'h13, 32'h21, 32'h20, 32'h1000, 32'h1000};
    for (int i = 0; i < 5; i++) begin
      do_req(wes[i], sizes[i], 1'b1, addrs[i], 32'h55555555, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'h0 || lat != 0) begin miscompares++; $display("FAIL error[%0d]: got err=%b rdata=%h lat=%0d want 1 00000000 0", i, er, rd, lat); end
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hAA991234) begin miscompares++; $display("FAIL error_no_write: got %h want aa991234", rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin miscompares++; $display("FAIL last_word: got rdata=%h err=%b want cafef00d 0", rd, er); end
  endtask

  task automatic test_backpressure();
    int n;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_sign = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL bp idle ready: got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_size = 2'b00; bus.req_addr = 32'h20;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    vectors++; if (n != 2) begin miscompares++; $display("FAIL bp first latency: got %0d want 2", n); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp hold[%0d]: got valid=%b rdata=%h err=%b ready=%b want 1 deadbeef 0 0", i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL bp bubble: got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL bp second accept: got ready=%b want 0", bus.req_ready); end
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    vectors++; if (n != 2 || bus.rsp_rdata !== 32'h000000AA || bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL bp second resp: got lat=%0d rdata=%h err=%b want 2 000000aa 0", n, bus.rsp_rdata, bus.rsp_err); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h01020304, rd, er, lat);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_sign = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h11111111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid in wait: got ready=%b want 0", bus.req_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid outputs: got ready=%b valid=%b rdata=%h err=%b want 1 0 00000000 0", bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wins: got ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid); end
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h01020304 || er !== 1'b0 || lat != 2) begin miscompares++; $display("FAIL rst_mid no write: got rdata=%h err=%b lat=%0d want 01020304 0 2", rd, er, lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_halfword();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
